// File: rtl/decoder_scan.sv
// decoder_scan: registered one-hot decoder with a direct mode (decode s) and a
// scan mode (decode an internal index that can be loaded or stepped up/down).
// At an end index the scan either wraps around or saturates, and the wrap
// output pulses for one cycle in either case.
module decoder_scan #(
  parameter int SEL_W = 2,
  parameter int WRAP  = 1,
  localparam int OUT_W = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [SEL_W-1:0] s,
  input  logic             load,
  input  logic             step,
  input  logic             dir,
  output logic [OUT_W-1:0] o,
  output logic [SEL_W-1:0] idx,
  output logic             valid,
  output logic             wrap
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  localparam logic [SEL_W-1:0] ZERO_C    = {SEL_W{1'b0}};
  localparam logic [SEL_W-1:0] MAX_C     = {SEL_W{1'b1}};
  localparam logic [SEL_W-1:0] ONE_C     = SEL_W'(1'b1);
  localparam bit               WRAP_EN_C = (WRAP != 32'sd0);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [SEL_W-1:0] idx_r;
  logic [SEL_W-1:0] idx_nxt_s;
  logic [OUT_W-1:0] o_r;
  logic [OUT_W-1:0] o_nxt_s;
  logic             valid_r;
  logic             valid_nxt_s;
  logic             wrap_r;
  logic             wrap_nxt_s;

  // One-hot image of an index value.
  function automatic logic [OUT_W-1:0] onehot_f(input logic [SEL_W-1:0] v);
    logic [OUT_W-1:0] r;
    r    = {OUT_W{1'b0}};
    r[v] = 1'b1;
    return r;
  endfunction

  // State and output registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      idx_r   <= ZERO_C;
      o_r     <= {OUT_W{1'b0}};
      valid_r <= 1'b0;
      wrap_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      o_r     <= o_nxt_s;
      valid_r <= valid_nxt_s;
      wrap_r  <= wrap_nxt_s;
    end
  end

  // Next state, next index (direct / load / step with wrap or saturate) and
  // next outputs. The entry edge from IDLE already applies the index update.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    wrap_nxt_s  = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (en) begin
          state_nxt_s = ST_ACTIVE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (!en) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ACTIVE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    if (en) begin
      if (!mode) begin
        idx_nxt_s = s;
      end else if (load) begin
        idx_nxt_s = s;
      end else if (step) begin
        if (!dir) begin
          if (idx_r == MAX_C) begin
            wrap_nxt_s = 1'b1;
            idx_nxt_s  = WRAP_EN_C ? ZERO_C : idx_r;
          end else begin
            idx_nxt_s = idx_r + ONE_C;
          end
        end else begin
          if (idx_r == ZERO_C) begin
            wrap_nxt_s = 1'b1;
            idx_nxt_s  = WRAP_EN_C ? MAX_C : idx_r;
          end else begin
            idx_nxt_s = idx_r - ONE_C;
          end
        end
      end else begin
        idx_nxt_s = idx_r;
      end
    end else begin
      idx_nxt_s = idx_r;
    end

    if (state_nxt_s == ST_ACTIVE) begin
      o_nxt_s     = onehot_f(idx_nxt_s);
      valid_nxt_s = 1'b1;
    end else begin
      o_nxt_s     = {OUT_W{1'b0}};
      valid_nxt_s = 1'b0;
    end
  end

  assign o     = o_r;
  assign idx   = idx_r;
  assign valid = valid_r;
  assign wrap  = wrap_r;

endmodule

// File: tb/tb_decoder_scan.sv
// Bench for decoder_scan: three instances (2-bit wrap, 3-bit wrap, 2-bit
// saturate) share one stimulus. Directed table + hand sequences compare to
// constants; a random phase compares to an arithmetic reference model.
module tb_decoder_scan;

  logic       clk = 1'b0;
  logic       rst, en, mode, load, step, dir;
  logic [2:0] s3;

  logic [3:0] o_a;  logic [1:0] idx_a;  logic valid_a, wrap_a;
  logic [7:0] o_b;  logic [2:0] idx_b;  logic valid_b, wrap_b;
  logic [3:0] o_c;  logic [1:0] idx_c;  logic valid_c, wrap_c;

  int nchk = 0;
  int nerr = 0;

  // reference model state per instance
  int m_idx[3];
  int m_valid[3];
  int m_wrap[3];
  int nn[3] = '{4, 8, 4};
  int wr[3] = '{1, 1, 0};

  always #5 clk = ~clk;

  decoder_scan #(.SEL_W(2), .WRAP(1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .s(s3[1:0]), .load(load),
    .step(step), .dir(dir), .o(o_a), .idx(idx_a), .valid(valid_a), .wrap(wrap_a));
  decoder_scan #(.SEL_W(3), .WRAP(1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .s(s3), .load(load),
    .step(step), .dir(dir), .o(o_b), .idx(idx_b), .valid(valid_b), .wrap(wrap_b));
  decoder_scan #(.SEL_W(2), .WRAP(0)) dut_c (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .s(s3[1:0]), .load(load),
    .step(step), .dir(dir), .o(o_c), .idx(idx_c), .valid(valid_c), .wrap(wrap_c));

  typedef struct {
    logic       en;
    logic       mode;
    logic [2:0] s;
    logic       load;
    logic       step;
    logic       dir;
    int         e_idx;
    int         e_o;
    int         e_valid;
    int         e_wrap;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 3; k++) begin
      int sv;
      int t;
      sv = int'(s3) % nn[k];
      m_wrap[k] = 0;
      if (rst) begin
        m_idx[k]   = 0;
        m_valid[k] = 0;
      end else begin
        m_valid[k] = en ? 1 : 0;
        if (en) begin
          if (!mode || load) begin
            m_idx[k] = sv;
          end else if (step) begin
            t = m_idx[k] + (dir ? -1 : 1);
            if (t < 0 || t >= nn[k]) begin
              m_wrap[k] = 1;
              if (wr[k] != 0) m_idx[k] = (t + nn[k]) % nn[k];
            end else begin
              m_idx[k] = t;
            end
          end
        end
      end
    end
  endtask

  // one rising edge, then sample #1 later and advance the model
  task automatic tick();
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic set_in(input logic e, input logic m, input logic [2:0] sv,
                        input logic l, input logic st, input logic d);
    en = e; mode = m; s3 = sv; load = l; step = st; dir = d;
  endtask

  task automatic chk_model();
    chk("a_idx",   int'(idx_a),   m_idx[0]);
    chk("a_o",     int'(o_a),     m_valid[0] != 0 ? (1 << m_idx[0]) : 0);
    chk("a_valid", int'(valid_a), m_valid[0]);
    chk("a_wrap",  int'(wrap_a),  m_wrap[0]);
    chk("b_idx",   int'(idx_b),   m_idx[1]);
    chk("b_o",     int'(o_b),     m_valid[1] != 0 ? (1 << m_idx[1]) : 0);
    chk("b_valid", int'(valid_b), m_valid[1]);
    chk("b_wrap",  int'(wrap_b),  m_wrap[1]);
    chk("c_idx",   int'(idx_c),   m_idx[2]);
    chk("c_o",     int'(o_c),     m_valid[2] != 0 ? (1 << m_idx[2]) : 0);
    chk("c_valid", int'(valid_c), m_valid[2]);
    chk("c_wrap",  int'(wrap_c),  m_wrap[2]);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_idx[k] = 0; m_valid[k] = 0; m_wrap[k] = 0;
    end
    rst = 1'b1;
    set_in(1'b1, 1'b1, 3'd5, 1'b1, 1'b1, 1'b0);

    // reset state, with other inputs active
    tick();
    tick();
    chk("rst_a_idx", int'(idx_a), 0);  chk("rst_a_o", int'(o_a), 0);
    chk("rst_a_valid", int'(valid_a), 0);  chk("rst_a_wrap", int'(wrap_a), 0);
    chk("rst_b_idx", int'(idx_b), 0);  chk("rst_b_o", int'(o_b), 0);
    chk("rst_c_valid", int'(valid_c), 0);  chk("rst_c_wrap", int'(wrap_c), 0);
    rst = 1'b0;

    // directed table against dut_a (SEL_W=2, wrap)
    tbl[0]  = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 0, 4'h1, 1, 0};
    tbl[1]  = '{1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1, 4'h2, 1, 0};
    tbl[2]  = '{1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 2, 4'h4, 1, 0};
    tbl[3]  = '{1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 3, 4'h8, 1, 0};
    tbl[4]  = '{1'b1, 1'b0, 3'd1, 1'b0, 1'b1, 1'b1, 1, 4'h2, 1, 0};
    tbl[5]  = '{1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 3, 4'h8, 1, 0};
    tbl[6]  = '{1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 2, 4'h4, 1, 0};
    tbl[7]  = '{1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 2, 4'h0, 0, 0};
    tbl[8]  = '{1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 2, 4'h4, 1, 0};
    tbl[9]  = '{1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 3, 4'h8, 1, 0};
    tbl[10] = '{1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 0, 4'h1, 1, 1};
    tbl[11] = '{1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 3, 4'h8, 1, 1};
    tbl[12] = '{1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1, 4'h2, 1, 0};
    tbl[13] = '{1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1, 4'h2, 1, 0};
    for (int i = 0; i < 14; i++) begin
      set_in(tbl[i].en, tbl[i].mode, tbl[i].s, tbl[i].load, tbl[i].step, tbl[i].dir);
      tick();
      chk($sformatf("tbl%0d_idx", i),   int'(idx_a),   tbl[i].e_idx);
      chk($sformatf("tbl%0d_o", i),     int'(o_a),     tbl[i].e_o);
      chk($sformatf("tbl%0d_valid", i), int'(valid_a), tbl[i].e_valid);
      chk($sformatf("tbl%0d_wrap", i),  int'(wrap_a),  tbl[i].e_wrap);
    end

    // rst pulsed between edges has no effect
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    set_in(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("glitch_idx", int'(idx_a), 1);
    chk("glitch_o", int'(o_a), 4'h2);

    // scan wrap on dut_b (SEL_W=3)
    set_in(1'b1, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0);
    tick();
    chk("sw_load_idx", int'(idx_b), 6);
    chk("sw_load_wrap", int'(wrap_b), 0);
    set_in(1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("sw1_idx", int'(idx_b), 7);  chk("sw1_o", int'(o_b), 8'h80);  chk("sw1_wrap", int'(wrap_b), 0);
    tick();
    chk("sw2_idx", int'(idx_b), 0);  chk("sw2_o", int'(o_b), 8'h01);  chk("sw2_wrap", int'(wrap_b), 1);
    tick();
    chk("sw3_idx", int'(idx_b), 1);  chk("sw3_o", int'(o_b), 8'h02);  chk("sw3_wrap", int'(wrap_b), 0);

    // saturate on dut_c (SEL_W=2, no wrap)
    set_in(1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("sat_load_idx", int'(idx_c), 0);
    set_in(1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1);
    tick();
    chk("sat_dn_idx", int'(idx_c), 0);  chk("sat_dn_o", int'(o_c), 4'h1);
    chk("sat_dn_wrap", int'(wrap_c), 1);
    set_in(1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("sat_up%0d_idx", i), int'(idx_c), (i < 3) ? i + 1 : 3);
      chk($sformatf("sat_up%0d_wrap", i), int'(wrap_c), (i == 3) ? 1 : 0);
    end
    set_in(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("sat_pulse_end", int'(wrap_c), 0);
    chk("sat_hold_o", int'(o_c), 4'h8);

    // reset mid-scan on dut_b
    set_in(1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0);
    tick();
    chk("mr_pre_idx", int'(idx_b), 5);
    rst = 1'b1;
    set_in(1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("mr_idx", int'(idx_b), 0);  chk("mr_o", int'(o_b), 0);
    chk("mr_valid", int'(valid_b), 0);  chk("mr_wrap", int'(wrap_b), 0);
    rst = 1'b0;
    set_in(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("mr_rel_o", int'(o_b), 8'h01);  chk("mr_rel_valid", int'(valid_b), 1);

    // randomized phase against the reference model
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      en   = ($urandom_range(0, 9) != 0);
      mode = ($urandom_range(0, 3) != 0);
      s3   = 3'($urandom_range(0, 7));
      load = ($urandom_range(0, 5) == 0);
      step = ($urandom_range(0, 2) != 0);
      dir  = 1'($urandom_range(0, 1));
      tick();
      chk_model();
    end

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/decoder_scan.md
DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 The block SHALL have parameter SEL_W, default 2, meaning select width; legal range 1..6.
REQ-002 The block SHALL have parameter WRAP, default 1, meaning scan at an end index: 1 = wrap around, 0 = saturate.
REQ-003 The block SHALL derive localparam OUT_W = 2**SEL_W, meaning one-hot output width.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  meaning: single clock; all state updates on its rising edge.
REQ-006 rst  input  1  meaning: synchronous, active-high reset.
REQ-007 en  input  1  meaning: enables decoding; 0 forces the output to zero.
REQ-008 mode  input  1  meaning: 0 = direct decode of s; 1 = scan (internal index).
REQ-009 s  input  SEL_W  meaning: select value, used in direct mode and on load.
REQ-010 load  input  1  meaning: scan mode only; copy s into the index.
REQ-011 step  input  1  meaning: scan mode only; advance the index by one.
REQ-012 dir  input  1  meaning: step direction; 0 = up (+1), 1 = down (-1).
REQ-013 o  output  OUT_W  meaning: registered one-hot decode; bit k is high when idx == k and the block is ACTIVE.
REQ-014 idx  output  SEL_W  meaning: current internal index.
REQ-015 valid  output  1  meaning: o holds a valid one-hot value.
REQ-016 wrap  output  1  meaning: one-cycle pulse on an index wrap (WRAP=1) or on a blocked step at an end (WRAP=0).

Function
REQ-017 The block SHALL implement a two-state FSM, IDLE and ACTIVE:
- IDLE -> ACTIVE on en=1.
- ACTIVE -> IDLE on en=0.
REQ-018 In IDLE, the block SHALL hold o=0 and valid=0, and SHALL retain idx.
REQ-019 The block SHALL register all outputs; o, valid and idx reflect the inputs sampled at the previous rising edge (latency 1 cycle).
REQ-020 On the IDLE->ACTIVE edge, idx SHALL update per mode in the same cycle; o SHALL be the one-hot of the new idx and valid=1.
REQ-021 In ACTIVE with mode=0, the block SHALL set idx <= s every cycle and ignore load, step and dir.
REQ-022 In ACTIVE with mode=1, load SHALL have priority over step:
- load=1 -> idx <= s.
- else step=1 -> idx +/- 1 per dir.
- else idx holds.
REQ-023 With WRAP=1, stepping up from OUT_W-1 SHALL yield 0 and stepping down from 0 SHALL yield OUT_W-1; wrap SHALL pulse high for exactly that cycle.
REQ-024 With WRAP=0, a step beyond either end SHALL leave idx unchanged and SHALL pulse wrap for one cycle.
REQ-025 The block SHALL never assert wrap on a load, in mode=0, or in IDLE.
REQ-026 While valid=1, o SHALL have exactly one bit set; while valid=0, o SHALL be all zeros.
REQ-027 A change of mode SHALL take effect on the next edge; idx SHALL carry over unchanged unless mode=0 or load overwrites it.
REQ-028 Index arithmetic SHALL be SEL_W bits wide, modulo 2**SEL_W, with no unsigned overflow beyond SEL_W bits.
REQ-029 In IDLE, the block SHALL ignore step and load.

Reset
REQ-030 On rst=1 at a rising edge, the block SHALL set state=IDLE, idx=0, o=0, valid=0 and wrap=0, overriding all other inputs.
REQ-031 Reset asserted mid-scan SHALL abort immediately; the first cycle after reset release with en=1 SHALL decode per REQ-020 from idx=0, or from s if loaded.
REQ-032 The block SHALL have no asynchronous behaviour; rst between edges SHALL have no effect.

Verification
REQ-033 Direct decode, SEL_W=2: en=1, mode=0, s=00,01,10,11 on successive cycles -> o=0001,0010,0100,1000 one cycle later each, valid=1, wrap=0.
REQ-034 Scan wrap, SEL_W=3, WRAP=1: load s=6, then step up x3 -> idx=7,0,1; o=10000000,00000001,00000010; wrap=1 only in the cycle idx goes 7->0.
REQ-035 Scan saturate, SEL_W=2, WRAP=0: load s=0, dir=1, step -> idx stays 0, o=0001, wrap pulses once; then dir=0, step x4 -> idx=1,2,3,3, wrap=1 on the fourth step only.
REQ-036 Load/step collision: mode=1, idx=1, load=1 with s=3 and step=1 in the same cycle -> idx=3, o=1000, wrap=0.
REQ-037 Enable drop: in ACTIVE with idx=2, en=0 -> next cycle o=0000, valid=0, idx=2; en=1 with mode=1 and no load/step -> o=0100.
REQ-038 Reset mid-operation: scanning at idx=5 (SEL_W=3), rst=1 for one edge -> idx=0, o=0, valid=0, wrap=0; after release with en=1, mode=1 -> o=00000001.
